vga_sync_gen: RTL
=================

# vga_sync_gen

Raster timing generator that produces the pixel position, visible flag and sync pulses consumed by the pixel generators (digit renderers, sprite and test-pattern blocks) and by the board's VGA output. It sits between the board clock and every per-pixel renderer: renderers map `(o_hpos, o_vpos, o_visible)` to colour, and this block drives the same coordinates plus `o_hsync`/`o_vsync` to the connector. Defaults give 640x480 at 60 Hz from a 25.175 MHz pixel rate.

## Interface
- `H_VISIBLE`, 640: active pixels per line
- `H_FRONT`, 16: horizontal front porch, in pixels
- `H_SYNC`, 96: hsync pulse width, in pixels
- `H_BACK`, 48: horizontal back porch, in pixels
- `V_VISIBLE`, 480: active lines per frame
- `V_FRONT`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vsync width, in lines
- `V_BACK`, 33: vertical back porch, in lines
- `SYNC_ACTIVE_HIGH`, 0: 0 means sync pulses are driven low; 1 means driven high
- `i_clk` in 1: single clock, rising edge
- `i_rst_n` in 1: reset, asynchronous, active-low
- `i_pix_ce` in 1: pixel clock enable; tie to 1 when `i_clk` is the pixel clock
- `o_hpos` out 10: current column, 0..H_TOTAL-1
- `o_vpos` out 10: current line, 0..V_TOTAL-1
- `o_visible` out 1: high iff `o_hpos < H_VISIBLE` and `o_vpos < V_VISIBLE`
- `o_hsync` out 1: horizontal sync, polarity set by `SYNC_ACTIVE_HIGH`
- `o_vsync` out 1: vertical sync, polarity set by `SYNC_ACTIVE_HIGH`
- `o_line_start` out 1: one-clock pulse when `o_hpos` becomes 0
- `o_frame_start` out 1: one-clock pulse when `(o_hpos, o_vpos)` becomes `(0,0)`

## Operation
- `H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK` (800); `V_TOTAL` is defined the same way (525). Both must be ≤1024; check with an elaboration-time assertion.
- Reset places the counters on the last pixel of the frame: `o_hpos = H_TOTAL-1`, `o_vpos = V_TOTAL-1`.
  - This point is in the back porch, so at reset `o_visible = 0`, both syncs are inactive, and both pulses are 0.
  - The first `i_pix_ce` after reset release therefore lands on (0,0) and raises `o_frame_start`.
- On each clock with `i_pix_ce = 1`:
  - `hpos` increments. At `H_TOTAL-1` it wraps to 0 and `vpos` increments.
  - `vpos` wraps to 0 at `V_TOTAL-1` when `hpos` also wraps.
- With `i_pix_ce = 0`, all counters and level outputs hold, and both pulses are 0.
- The hsync active window is `H_VISIBLE+H_FRONT ≤ hpos < H_VISIBLE+H_FRONT+H_SYNC`, i.e. 656..751. The vsync window uses the analogous line range, 490..491.
- Vsync transitions on the pixel where `hpos` wraps to 0 (line-aligned). It never changes mid-line.
- Reset asserted mid-frame returns every output to its reset value immediately (asynchronous). Timing restarts from (0,0) on the first enable after release; a partial frame is acceptable.

## Timing
- All outputs are registered from the same edge. `o_visible`, the syncs and the pulses are decoded from the next-state counter values, so they are exactly aligned with `o_hpos`/`o_vpos` and have zero lag relative to position.
- Downstream renderers that register colour add their own latency and must delay syncs to match; this block does not compensate.
- `o_line_start` and `o_frame_start` are high for exactly one `i_clk`, the cycle after the advancing edge. They are never stretched across cycles with `i_pix_ce = 0`.
- `o_frame_start` implies `o_line_start` in the same cycle.

## Configuration
- `VGA_SYNC_FRAME_COUNT_EN` defined:
  - Adds output `o_frame_cnt` (8 bits). It resets to 0, increments on every `o_frame_start` cycle, and wraps 255→0.
  - Intended for animation and blink effects in renderers.
- `VGA_SYNC_FRAME_COUNT_EN` undefined: the port and its register do not exist.

## Structure
- Package `vga_timing_pkg` holds:
  - the 640x480 default timing constants;
  - the `H_TOTAL`/`V_TOTAL` derivations;
  - a `pos_t` typedef (10-bit position).
- Sub-module `sync_axis_counter` is instantiated twice, for the horizontal and vertical axes. It provides a wrapping counter with enable, sync-window decode and a wrap flag.

## Test plan
- Reset release with `i_pix_ce = 1` → first clock shows hpos 0, vpos 0, visible 1, frame_start 1, line_start 1; the next clock shows hpos 1 with both pulses 0.
- Free-run one line → hsync active (low) for hpos 656..751 only (96 clocks); visible falls at hpos 640; line_start repeats every 800 clocks.
- Free-run a full frame → vsync active for vpos 490..491 only, asserted from hpos 0 of line 490; frame_start period is exactly 420000 clocks.
- `i_pix_ce` toggled 1/0 (every other cycle) → outputs advance one pixel per two clocks; frame_start remains a single-clock pulse; frame period is 840000 clocks.
- Assert `i_rst_n` at hpos 700, vpos 491 → outputs go immediately to hpos 799, vpos 524, visible 0, syncs inactive; after release, the next enable gives (0,0) with frame_start.
- With `VGA_SYNC_FRAME_COUNT_EN` and `SYNC_ACTIVE_HIGH = 1` → frame_cnt reads 3 after 3 frame_starts and wraps to 0 after 256; sync pulses are high-true.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants and types for the VGA sync generator.
// Defaults describe 640x480 at 60 Hz from a 25.175 MHz pixel rate.
package vga_timing_pkg;

  localparam int unsigned POS_W   = 10;
  localparam int unsigned POS_MAX = 1 << POS_W;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;

  function automatic int unsigned axis_total(input int unsigned visible, input int unsigned front,
                                             input int unsigned sync, input int unsigned back);
    return visible + front + sync + back;
  endfunction

  localparam int unsigned DEF_H_TOTAL = axis_total(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
  localparam int unsigned DEF_V_TOTAL = axis_total(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

  typedef logic [POS_W-1:0] pos_t;
  // One extra bit so window bounds equal to POS_MAX still compare correctly.
  typedef logic [POS_W:0]   cmp_t;

endpackage

// File: rtl/vga_sync_gen_axis.sv
// sync_axis_counter: one raster axis -- wrapping position counter with enable,
// plus next-state decode of the visible region and sync window for the parent to register.
module sync_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned TOTAL      = DEF_H_TOTAL,
  parameter int unsigned VISIBLE    = DEF_H_VISIBLE,
  parameter int unsigned SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT,
  parameter int unsigned SYNC_END   = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [POS_W-1:0] pos_q,
  output logic             wrap_c,
  output logic             active_c,
  output logic             sync_c
);

  localparam pos_t LAST = pos_t'(TOTAL - 1);

  pos_t pos_d;

  // Next position and decodes of that next position, so registered outputs align with pos_q.
  always_comb begin
    pos_d    = pos_q;
    wrap_c   = en && (pos_q == LAST);
    if (wrap_c) begin
      pos_d = '0;
    end else if (en) begin
      pos_d = pos_q + pos_t'(1);
    end
    active_c = {1'b0, pos_d} < cmp_t'(VISIBLE);
    sync_c   = ({1'b0, pos_d} >= cmp_t'(SYNC_START)) && ({1'b0, pos_d} < cmp_t'(SYNC_END));
  end

  // Reset parks the axis on its last position so the first enable lands on 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q <= LAST;
    end else begin
      pos_q <= pos_d;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel position, visible flag, syncs and line/frame pulses.
// Optional VGA_SYNC_FRAME_COUNT_EN adds an 8-bit wrapping frame counter output.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE        = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT          = DEF_H_FRONT,
  parameter int unsigned H_SYNC           = DEF_H_SYNC,
  parameter int unsigned H_BACK           = DEF_H_BACK,
  parameter int unsigned V_VISIBLE        = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT          = DEF_V_FRONT,
  parameter int unsigned V_SYNC           = DEF_V_SYNC,
  parameter int unsigned V_BACK           = DEF_V_BACK,
  parameter int unsigned SYNC_ACTIVE_HIGH = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pix_ce,
  output logic [POS_W-1:0] o_hpos,
  output logic [POS_W-1:0] o_vpos,
  output logic             o_visible,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_line_start,
  output logic             o_frame_start
`ifdef VGA_SYNC_FRAME_COUNT_EN
  ,
  output logic [7:0]       o_frame_cnt
`endif
);

  localparam int unsigned H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam logic        SYNC_ON = 1'(SYNC_ACTIVE_HIGH != 0);

  if (H_TOTAL > POS_MAX || V_TOTAL > POS_MAX) begin : g_total_check
    $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  logic h_wrap_c, h_active_c, h_sync_c;
  logic v_wrap_c, v_active_c, v_sync_c;
  pos_t hpos_q, vpos_q;

  logic visible_q, visible_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  sync_axis_counter #(
    .TOTAL      (H_TOTAL),
    .VISIBLE    (H_VISIBLE),
    .SYNC_START (H_VISIBLE + H_FRONT),
    .SYNC_END   (H_VISIBLE + H_FRONT + H_SYNC)
  ) u_h_axis (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .en       (i_pix_ce),
    .pos_q    (hpos_q),
    .wrap_c   (h_wrap_c),
    .active_c (h_active_c),
    .sync_c   (h_sync_c)
  );

  // The vertical axis steps only on horizontal wrap, which keeps vsync line-aligned.
  sync_axis_counter #(
    .TOTAL      (V_TOTAL),
    .VISIBLE    (V_VISIBLE),
    .SYNC_START (V_VISIBLE + V_FRONT),
    .SYNC_END   (V_VISIBLE + V_FRONT + V_SYNC)
  ) u_v_axis (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .en       (h_wrap_c),
    .pos_q    (vpos_q),
    .wrap_c   (v_wrap_c),
    .active_c (v_active_c),
    .sync_c   (v_sync_c)
  );

  always_comb begin
    visible_d     = h_active_c && v_active_c;
    hsync_d       = h_sync_c ? SYNC_ON : ~SYNC_ON;
    vsync_d       = v_sync_c ? SYNC_ON : ~SYNC_ON;
    line_start_d  = h_wrap_c;
    frame_start_d = h_wrap_c && v_wrap_c;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      visible_q     <= 1'b0;
      hsync_q       <= ~SYNC_ON;
      vsync_q       <= ~SYNC_ON;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      visible_q     <= visible_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_hpos        = hpos_q;
  assign o_vpos        = vpos_q;
  assign o_visible     = visible_q;
  assign o_hsync       = hsync_q;
  assign o_vsync       = vsync_q;
  assign o_line_start  = line_start_q;
  assign o_frame_start = frame_start_q;

`ifdef VGA_SYNC_FRAME_COUNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_start_d) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_cnt_q <= 8'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign o_frame_cnt = frame_cnt_q;
`endif

endmodule
